// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory port: instruction fetch vs load/store.
// Each access runs IDLE -> BUSY (MEM_LAT cycles) -> DONE (one-cycle ack to the owner).
module mem_port_arbiter #(
   parameter int WIDTH   = 32,
   parameter int MEM_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req,
   input  logic [WIDTH-1:0] i_addr,
   output logic             i_ack,
   output logic [WIDTH-1:0] i_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             d_ack,
   output logic [WIDTH-1:0] d_rdata,
   output logic             mem_sel,
   output logic             mem_en,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

   state_t     state, state_nxt;
   logic       owner;       // 0 = fetch, 1 = data
   logic       last_grant;
   logic [3:0] cnt;
   logic       grant;
   logic       grant_id;

   assign mem_sel = owner;

   // NOTE: every output of this block gets a default before the case, so no path leaves a latch.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_id  = 1'b0;
      mem_en    = 1'b0;
      i_ack     = 1'b0;
      d_ack     = 1'b0;
      case (state)
         IDLE: begin
            if (i_req && d_req) begin
               grant    = 1'b1;
               grant_id = ~last_grant;
            end else if (i_req || d_req) begin
               grant    = 1'b1;
               grant_id = d_req;
            end
            if (grant) state_nxt = BUSY;
         end
         BUSY: begin
            mem_en = 1'b1;
            if (cnt == 4'd0) state_nxt = DONE;
         end
         DONE: begin
            i_ack     = ~owner;
            d_ack     = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= 4'd0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner      <= grant_id;
            last_grant <= grant_id;
            cnt        <= LAT_INIT;
            if (grant_id) begin
               mem_addr  <= d_addr;
               mem_we    <= d_we;
               mem_wdata <= d_wdata;
            end else begin
               mem_addr  <= i_addr;
               mem_we    <= 1'b0;
               mem_wdata <= '0;
            end
         end else if (state == BUSY) begin
            if (cnt == 4'd0) begin
               // Write strobe covers only the BUSY cycles; stores leave both rdata registers alone.
               mem_we <= 1'b0;
               if (!mem_we) begin
                  if (owner) d_rdata <= mem_rdata;
                  else       i_rdata <= mem_rdata;
               end
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random fetch/load/store traffic against a memory model
// that only presents valid read data in the MEM_LAT-th enabled cycle.
module tb_mem_port_arbiter;
   parameter int MEM_LAT = 2;
   localparam int WIDTH = 32;
   localparam int L = MEM_LAT;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             i_req = 1'b0;
   logic [WIDTH-1:0] i_addr = '0;
   logic             i_ack;
   logic [WIDTH-1:0] i_rdata;
   logic             d_req = 1'b0;
   logic             d_we = 1'b0;
   logic [WIDTH-1:0] d_addr = '0;
   logic [WIDTH-1:0] d_wdata = '0;
   logic             d_ack;
   logic [WIDTH-1:0] d_rdata;
   logic             mem_sel;
   logic             mem_en;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(WIDTH), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference memory (updated when a store is issued) and the physical memory the DUT talks to.
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] phys    [logic [31:0]];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] phys_read(input logic [31:0] a);
      return phys.exists(a) ? phys[a] : init_word(a);
   endfunction

   logic [31:0] i_exp [$];
   logic [31:0] d_exp [$];
   logic [31:0] last_load = '0;

   // Memory: read data is valid only in the MEM_LAT-th enabled cycle, garbage otherwise.
   int en_cycles = 0;
   bit abort_ok  = 1'b0;
   always @(posedge clk) begin
      #1;
      if (mem_en) begin
         en_cycles++;
         if (en_cycles == L) begin
            if (mem_we) phys[mem_addr] = mem_wdata;
            mem_rdata = phys_read(mem_addr);
         end else begin
            mem_rdata = $urandom;
         end
      end else begin
         if (en_cycles != 0 && !abort_ok) check("en_run_len", en_cycles, L);
         en_cycles = 0;
         mem_rdata = $urandom;
      end
   end

   // Monitor: pops the scoreboard on each ack and checks the port against the owner's request.
   logic prev_i_ack = 1'b0;
   logic prev_d_ack = 1'b0;
   always @(posedge clk) begin
      #2;
      if (i_ack) begin
         check("i_ack_width", prev_i_ack, 1'b0);
         if (i_exp.size() == 0) check("i_ack_unexpected", i_ack, 1'b0);
         else                   check("i_rdata", i_rdata, i_exp.pop_front());
      end
      if (d_ack) begin
         check("d_ack_width", prev_d_ack, 1'b0);
         if (d_exp.size() == 0) check("d_ack_unexpected", d_ack, 1'b0);
         else                   check("d_rdata", d_rdata, d_exp.pop_front());
      end
      prev_i_ack = i_ack;
      prev_d_ack = d_ack;
      if (mem_en) begin
         if (mem_sel == 1'b0) begin
            check("port_i_req", i_req, 1'b1);
            check("port_i_addr", mem_addr, i_addr);
            check("port_i_we", mem_we, 1'b0);
            check("port_i_wdata", mem_wdata, 32'h0);
         end else begin
            check("port_d_req", d_req, 1'b1);
            check("port_d_addr", mem_addr, d_addr);
            check("port_d_we", mem_we, d_we);
            if (d_we) check("port_d_wdata", mem_wdata, d_wdata);
         end
      end
   end

   // Requesters: call at #1 after an edge; return at #1 of the ack cycle with req dropped.
   task automatic do_fetch(input logic [31:0] a, output int lat);
      i_exp.push_back(ref_read(a));
      i_addr = a;
      i_req  = 1'b1;
      lat    = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!i_ack && lat < 200);
      if (!i_ack) check("i_timeout", i_ack, 1'b1);
      i_req = 1'b0;
   endtask

   task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int lat);
      if (we) ref_mem[a] = wd;
      else    last_load = ref_read(a);
      d_exp.push_back(last_load);
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      d_req   = 1'b1;
      lat     = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!d_ack && lat < 200);
      if (!d_ack) check("d_timeout", d_ack, 1'b1);
      d_req = 1'b0;
   endtask

   task automatic idle_gap(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int li, ld;
      phys[32'h100]    = 32'h0000_0013;
      ref_mem[32'h100] = 32'h0000_0013;

      #1 rst = 1'b1;
      #1;
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_i_ack", i_ack, 1'b0);
      check("rst_d_ack", d_ack, 1'b0);
      check("rst_mem_sel", mem_sel, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle_gap(1);

      // Single fetch, store, load-back.
      do_fetch(32'h100, li);
      check("fetch_lat", li, L + 1);
      idle_gap(1);
      do_data(1'b1, 32'h2000, 32'hDEAD_BEEF, ld);
      check("store_lat", ld, L + 1);
      idle_gap(1);
      do_data(1'b0, 32'h2000, 32'h0, ld);
      check("load_lat", ld, L + 1);

      // Two ties in a row: fetch then data each time.
      for (int t = 0; t < 2; t++) begin
         idle_gap(1);
         fork
            do_fetch(32'h104, li);
            do_data(1'b0, 32'h2004, 32'h0, ld);
         join
         check("tie_i_lat", li, L + 1);
         check("tie_d_lat", ld, 2 * L + 3);
      end

      // Continuous contention: grants alternate i,d,i,d...
      idle_gap(1);
      fork
         begin
            int lf;
            for (int k = 0; k < 4; k++) begin
               do_fetch(32'h200 + 32'(4 * k), lf);
               check("cont_i_lat", lf, (k == 0) ? L + 1 : 2 * L + 4);
            end
         end
         begin
            int lg;
            for (int k = 0; k < 4; k++) begin
               do_data(k[0], 32'h2008, $urandom, lg);
               check("cont_d_lat", lg, (k == 0) ? 2 * L + 3 : 2 * L + 4);
            end
         end
      join

      // Random traffic.
      idle_gap(1);
      fork
         begin
            int lf;
            for (int k = 0; k < 24; k++) begin
               idle_gap($urandom_range(0, 3));
               do_fetch({20'h0, 10'($urandom), 2'b00}, lf);
               check("rand_i_lat_range", 32'(lf >= L + 1 && lf <= 2 * L + 4), 1);
            end
         end
         begin
            int lg;
            for (int k = 0; k < 24; k++) begin
               idle_gap($urandom_range(0, 3));
               do_data(1'($urandom), 32'h2000 + 32'(4 * $urandom_range(0, 7)), $urandom, lg);
               check("rand_d_lat_range", 32'(lg >= L + 1 && lg <= 2 * L + 4), 1);
            end
         end
      join

      // Reset during the second BUSY cycle of a load aborts it.
      idle_gap(1);
      d_we   = 1'b0;
      d_addr = 32'h2010;
      d_req  = 1'b1;
      repeat ((L >= 2) ? 2 : 1) @(posedge clk);
      #3;
      check("abort_pre_en", mem_en, 1'b1);
      abort_ok = 1'b1;
      rst = 1'b1;
      #1;
      check("abort_mem_en", mem_en, 1'b0);
      check("abort_mem_we", mem_we, 1'b0);
      check("abort_d_ack", d_ack, 1'b0);
      check("abort_d_rdata", d_rdata, 32'h0);
      check("abort_mem_sel", mem_sel, 1'b0);
      d_req = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      idle_gap(3);
      check("post_rst_mem_en", mem_en, 1'b0);
      check("post_rst_mem_sel", mem_sel, 1'b0);
      check("post_rst_d_rdata", d_rdata, 32'h0);
      abort_ok = 1'b0;
      ref_mem.delete();
      phys.delete();

      // After reset the first tie goes to fetch again.
      fork
         do_fetch(32'h300, li);
         do_data(1'b0, 32'h2014, 32'h0, ld);
      join
      check("rst_tie_i_lat", li, L + 1);
      check("rst_tie_d_lat", ld, 2 * L + 3);

      idle_gap(3);
      check("i_queue_drained", i_exp.size(), 0);
      check("d_queue_drained", d_exp.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
